control_unit: RTL and testbench

Moore-style control sequencer for the RISC CPU datapath. It steps each instruction through fixed control steps (fetch T0–T2, execute T3–T7) and drives every datapath strobe. This includes the Gra/Grb/Grc/Rin/Rout/BAout lines consumed by the register select-and-encode stage directly downstream. It reads the opcode from the datapath IR and the branch condition from the CON flip-flop.

---
 rtl/cpu_pkg.sv | 76 +++++++
 rtl/control_unit.sv | 183 ++++++++++++++++++
 tb/tb_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction opcodes, ALU operation codes and the
// control sequencer state encoding.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // The ALU decodes the same 5-bit codes as the instruction opcodes.
    localparam logic [4:0] ALU_ADD  = OP_ADD;
    localparam logic [4:0] ALU_SUB  = OP_SUB;
    localparam logic [4:0] ALU_AND  = OP_AND;
    localparam logic [4:0] ALU_OR   = OP_OR;
    localparam logic [4:0] ALU_ROR  = OP_ROR;
    localparam logic [4:0] ALU_ROL  = OP_ROL;
    localparam logic [4:0] ALU_SHR  = OP_SHR;
    localparam logic [4:0] ALU_SHRA = OP_SHRA;
    localparam logic [4:0] ALU_SHL  = OP_SHL;
    localparam logic [4:0] ALU_DIV  = OP_DIV;
    localparam logic [4:0] ALU_MUL  = OP_MUL;
    localparam logic [4:0] ALU_NEG  = OP_NEG;
    localparam logic [4:0] ALU_NOT  = OP_NOT;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    // Final execute step of each instruction class; unknown opcodes run as nop.
    function automatic state_t last_step(input logic [4:0] op);
        state_t s;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
            OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: s = S_T5;
            OP_NEG, OP_NOT, OP_JAL:                   s = S_T4;
            OP_MUL, OP_DIV, OP_BR:                    s = S_T6;
            OP_LD, OP_ST:                             s = S_T7;
            default:                                  s = S_T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Moore control sequencer: fetch in T0-T2, execute in T3-T7, one step per clock.
// Strobes decode combinationally from state and IR; no wait states or backpressure.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        stop,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        CONin,
    output logic        OutPortin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  ALU_op,
    output logic        Clear,
    output logic        Run
);

    state_t     state;
    state_t     next_state;
    logic [4:0] op;
    logic       ir_unused;

    assign op = IR[31:27];
    // Register and immediate fields are decoded by the select-and-encode stage.
    assign ir_unused = ^IR[26:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (state == S_RESET) begin
            next_state = S_T0;
        end else if (state == S_HALT) begin
            next_state = S_HALT;
        end else if (state == S_T3 && op == OP_HALT) begin
            next_state = S_HALT;
        end else if (state >= S_T3 && (state == last_step(op) || state == S_T7)) begin
            next_state = stop ? S_HALT : S_T0;
        end else begin
            next_state = state_t'(state + 4'd1);
        end
    end

    always_comb begin
        PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
        PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0;
        CONin = 1'b0; OutPortin = 1'b0; IncPC = 1'b0; Read = 1'b0;
        Write = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; ALU_op = 5'b00000;
        Clear = 1'b0; Run = 1'b1;

        case (state)
            S_RESET: Clear = 1'b1;
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_HALT: Run = 1'b0;
            default: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                        case (state)
                            S_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                            S_T4: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = op; end
                            S_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            S_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                            S_T4: begin
                                Cout = 1'b1;
                                Zin  = 1'b1;
                                ALU_op = (op == OP_ADDI) ? ALU_ADD :
                                         (op == OP_ANDI) ? ALU_AND : ALU_OR;
                            end
                            S_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state)
                            S_T3: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = op; end
                            S_T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state)
                            S_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                            S_T4: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = op; end
                            S_T5: begin Zlowout = 1'b1; LOin = 1'b1; end
                            S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state)
                            S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                            S_T4: begin Cout = 1'b1; Zin = 1'b1; ALU_op = ALU_ADD; end
                            S_T5: begin
                                Zlowout = 1'b1;
                                Gra   = (op == OP_LDI);
                                Rin   = (op == OP_LDI);
                                MARin = (op != OP_LDI);
                            end
                            S_T6: begin
                                MDRin = (op != OP_LDI);
                                Read  = (op == OP_LD);
                                Gra   = (op == OP_ST);
                                Rout  = (op == OP_ST);
                            end
                            S_T7: begin
                                MDRout = (op == OP_LD);
                                Gra    = (op == OP_LD);
                                Rin    = (op == OP_LD);
                                Write  = (op == OP_ST);
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state)
                            S_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                            S_T4: begin PCout = 1'b1; Yin = 1'b1; end
                            S_T5: begin Cout = 1'b1; Zin = 1'b1; ALU_op = ALU_ADD; end
                            // Target is always formed; only a taken branch loads it.
                            S_T6: begin Zlowout = 1'b1; PCin = CON_FF; end
                            default: ;
                        endcase
                    end
                    OP_JR: if (state == S_T3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_JAL: begin
                        case (state)
                            S_T3: begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                            S_T4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_IN:   if (state == S_T3) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_OUT:  if (state == S_T3) begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    OP_MFHI: if (state == S_T3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFLO: if (state == S_T3) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-step strobe vectors checked against hand-built tables.
module tb_control_unit;

    logic        clock;
    logic        reset;
    logic [31:0] IR;
    logic        CON_FF;
    logic        stop;
    logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortin, IncPC;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Clear, Run;
    logic [4:0] ALU_op;

    int total = 0;
    int bad   = 0;

    localparam logic [28:0] PCOUT = 29'd1 << 28, MDROUT = 29'd1 << 27, ZHIGHOUT = 29'd1 << 26;
    localparam logic [28:0] ZLOWOUT = 29'd1 << 25, HIOUT = 29'd1 << 24, LOOUT = 29'd1 << 23;
    localparam logic [28:0] INPORTOUT = 29'd1 << 22, COUT = 29'd1 << 21, PCIN = 29'd1 << 20;
    localparam logic [28:0] IRIN = 29'd1 << 19, MARIN = 29'd1 << 18, MDRIN = 29'd1 << 17;
    localparam logic [28:0] YIN = 29'd1 << 16, ZIN = 29'd1 << 15, HIIN = 29'd1 << 14;
    localparam logic [28:0] LOIN = 29'd1 << 13, CONIN = 29'd1 << 12, OUTPORTIN = 29'd1 << 11;
    localparam logic [28:0] INCPC = 29'd1 << 10, READ = 29'd1 << 9, WRITE = 29'd1 << 8;
    localparam logic [28:0] GRA = 29'd1 << 7, GRB = 29'd1 << 6, GRC = 29'd1 << 5;
    localparam logic [28:0] RIN = 29'd1 << 4, ROUT = 29'd1 << 3, BAOUT = 29'd1 << 2;
    localparam logic [28:0] CLEAR = 29'd1 << 1, RUN = 29'd1;

    localparam logic [28:0] F0 = PCOUT | MARIN | INCPC | ZIN | RUN;
    localparam logic [28:0] F1 = ZLOWOUT | PCIN | READ | MDRIN | RUN;
    localparam logic [28:0] F2 = MDROUT | IRIN | RUN;
    localparam logic [28:0] RST = CLEAR | RUN;

    wire [28:0] strobes = {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout,
                           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortin,
                           IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Clear, Run};

    control_unit dut (
        .clock(clock), .reset(reset), .IR(IR), .CON_FF(CON_FF), .stop(stop),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortin(OutPortin), .IncPC(IncPC),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .ALU_op(ALU_op), .Clear(Clear), .Run(Run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Two reset cycles, then T0; leaves the bench at the T0 sample point.
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            total++;
            if (strobes !== RST) begin
                bad++;
                $display("FAIL reset cycle %0d: strobes=%h want %h", i, strobes, RST);
            end
        end
        total++;
        if (ALU_op !== 5'b00000) begin
            bad++;
            $display("FAIL reset alu_op: got %b want 00000", ALU_op);
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (strobes !== F0) begin
            bad++;
            $display("FAIL reset_to_t0: strobes=%h want %h", strobes, F0);
        end
    endtask

    task automatic test_add();
        logic [28:0] exp [0:5];
        exp = '{F1, F2, GRB | ROUT | YIN | RUN, GRC | ROUT | ZIN | RUN,
                ZLOWOUT | GRA | RIN | RUN, F0};
        IR = 32'h1A8B_8000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            total++;
            if (strobes !== exp[i]) begin
                bad++;
                $display("FAIL add step %0d: strobes=%h want %h", i + 1, strobes, exp[i]);
            end
            if (i == 3) begin
                total++;
                if (ALU_op !== 5'b00011) begin
                    bad++;
                    $display("FAIL add alu_op: got %b want 00011", ALU_op);
                end
            end
        end
    endtask

    task automatic test_ld();
        logic [28:0] exp [0:7];
        exp = '{F1, F2, GRB | BAOUT | YIN | RUN, COUT | ZIN | RUN, ZLOWOUT | MARIN | RUN,
                READ | MDRIN | RUN, MDROUT | GRA | RIN | RUN, F0};
        IR = 32'h0123_4567;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            total++;
            if (strobes !== exp[i]) begin
                bad++;
                $display("FAIL ld step %0d: strobes=%h want %h", i + 1, strobes, exp[i]);
            end
            if (i == 3) begin
                total++;
                if (ALU_op !== 5'b00011) begin
                    bad++;
                    $display("FAIL ld alu_op: got %b want 00011", ALU_op);
                end
            end
        end
    endtask

    task automatic test_br();
        logic [28:0] exp [0:6];
        for (int c = 0; c < 2; c++) begin
            CON_FF = (c == 1);
            IR = 32'h9880_0000;
            exp = '{F1, F2, GRA | ROUT | CONIN | RUN, PCOUT | YIN | RUN, COUT | ZIN | RUN,
                    ZLOWOUT | RUN | ((c == 1) ? PCIN : 29'd0), F0};
            for (int i = 0; i < 7; i++) begin
                @(negedge clock);
                total++;
                if (strobes !== exp[i]) begin
                    bad++;
                    $display("FAIL br con=%0d step %0d: strobes=%h want %h", c, i + 1, strobes, exp[i]);
                end
            end
        end
        CON_FF = 1'b0;
    endtask

    // Short and mixed instructions: jr, mfhi, neg, jal, andi, st, undefined opcode.
    task automatic test_short();
        logic [28:0] exp [0:7];
        int n;
        int alu_i;
        logic [4:0] alu_want;
        for (int k = 0; k < 7; k++) begin
            alu_i = -1;
            alu_want = 5'b00000;
            case (k)
                0: begin IR = 32'hA000_0000; n = 4;
                   exp = '{F1, F2, GRA | ROUT | PCIN | RUN, F0, 0, 0, 0, 0}; end
                1: begin IR = 32'hC000_0000; n = 4;
                   exp = '{F1, F2, HIOUT | GRA | RIN | RUN, F0, 0, 0, 0, 0}; end
                2: begin IR = 32'h8800_0000; n = 5; alu_i = 2; alu_want = 5'b10001;
                   exp = '{F1, F2, GRB | ROUT | ZIN | RUN, ZLOWOUT | GRA | RIN | RUN, F0, 0, 0, 0}; end
                3: begin IR = 32'hA800_0000; n = 5;
                   exp = '{F1, F2, PCOUT | GRB | RIN | RUN, GRA | ROUT | PCIN | RUN, F0, 0, 0, 0}; end
                4: begin IR = 32'h6800_0000; n = 6; alu_i = 3; alu_want = 5'b00101;
                   exp = '{F1, F2, GRB | ROUT | YIN | RUN, COUT | ZIN | RUN,
                           ZLOWOUT | GRA | RIN | RUN, F0, 0, 0}; end
                5: begin IR = 32'h1000_0000; n = 8;
                   exp = '{F1, F2, GRB | BAOUT | YIN | RUN, COUT | ZIN | RUN, ZLOWOUT | MARIN | RUN,
                           GRA | ROUT | MDRIN | RUN, WRITE | RUN, F0}; end
                default: begin IR = 32'hF800_0000; n = 4;
                   exp = '{F1, F2, RUN, F0, 0, 0, 0, 0}; end
            endcase
            for (int i = 0; i < n; i++) begin
                @(negedge clock);
                total++;
                if (strobes !== exp[i]) begin
                    bad++;
                    $display("FAIL short op=%b step %0d: strobes=%h want %h", IR[31:27], i + 1, strobes, exp[i]);
                end
                if (i == alu_i) begin
                    total++;
                    if (ALU_op !== alu_want) begin
                        bad++;
                        $display("FAIL short op=%b alu_op: got %b want %b", IR[31:27], ALU_op, alu_want);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [28:0] exp [0:3];
        exp = '{F1, F2, GRA | ROUT | YIN | RUN, GRB | ROUT | ZIN | RUN};
        IR = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            total++;
            if (strobes !== exp[i]) begin
                bad++;
                $display("FAIL mul step %0d: strobes=%h want %h", i + 1, strobes, exp[i]);
            end
        end
        total++;
        if (ALU_op !== 5'b10000) begin
            bad++;
            $display("FAIL mul alu_op: got %b want 10000", ALU_op);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (strobes !== RST) begin
            bad++;
            $display("FAIL mul_reset: strobes=%h want %h", strobes, RST);
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (strobes !== F0) begin
            bad++;
            $display("FAIL mul_reset_t0: strobes=%h want %h", strobes, F0);
        end
    endtask

    // stop held high all instruction long must only act on the last step.
    task automatic test_stop();
        logic [28:0] exp [0:5];
        exp = '{F1, F2, GRB | ROUT | YIN | RUN, GRC | ROUT | ZIN | RUN,
                ZLOWOUT | GRA | RIN | RUN, 29'd0};
        IR = 32'h1A8B_8000;
        stop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            total++;
            if (strobes !== exp[i]) begin
                bad++;
                $display("FAIL stop step %0d: strobes=%h want %h", i + 1, strobes, exp[i]);
            end
        end
        stop = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (strobes !== RST) begin
            bad++;
            $display("FAIL stop_reset: strobes=%h want %h", strobes, RST);
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (strobes !== F0) begin
            bad++;
            $display("FAIL stop_reset_t0: strobes=%h want %h", strobes, F0);
        end
    endtask

    task automatic test_halt();
        logic [28:0] exp [0:2];
        exp = '{F1, F2, RUN};
        IR = 32'hD800_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (strobes !== exp[i]) begin
                bad++;
                $display("FAIL halt step %0d: strobes=%h want %h", i + 1, strobes, exp[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            total++;
            if (strobes !== 29'd0) begin
                bad++;
                $display("FAIL halt_hold cycle %0d: strobes=%h want 0", i, strobes);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (strobes !== RST) begin
            bad++;
            $display("FAIL halt_reset: strobes=%h want %h", strobes, RST);
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (strobes !== F0) begin
            bad++;
            $display("FAIL halt_reset_t0: strobes=%h want %h", strobes, F0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        IR     = 32'h0;
        CON_FF = 1'b0;
        stop   = 1'b0;
        test_reset();
        test_add();
        test_ld();
        test_br();
        test_short();
        test_reset_mid_mul();
        test_stop();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
